// File: rtl/pulse_source_gen.sv
// Multi-channel pulse/rect sample generator: each channel plays a delay, linear rise, high
// plateau, linear fall and low plateau, either once or for a programmed number of periods.
module pulse_source_gen #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int CW  = 16,
  parameter int EW  = 4,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DW  = (W > CW + 1) ? W : CW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [2:0]       cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  output logic             cfg_err,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  output logic [NCH*W-1:0] wave_out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done
);

  localparam int PW = W + 1 + (1 << EW);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_RISE, S_HIGH, S_FALL, S_LOW, S_DONE
  } state_t;

  logic w_chInRange;
  logic w_chBusy;
  logic r_cfgErr;

  assign w_chInRange = ({1'b0, cfg_ch} < (CHW + 1)'(NCH));
  assign w_chBusy    = w_chInRange ? busy[cfg_ch] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_cfgErr <= 1'b0;
    else     r_cfgErr <= cfg_we && w_chBusy;
  end

  assign cfg_err = r_cfgErr;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    state_t              r_state, w_nextState, w_endState;
    logic [CW-1:0]       r_cnt, w_nextCnt, r_per, w_nextPer, w_perInc;
    logic [CW-1:0]       r_td, r_th, r_tl, r_count, w_riseLast, w_fallLast;
    logic [EW-1:0]       r_trExp, r_tfExp, w_exp;
    logic signed [W-1:0] r_iv, r_pv, r_wave, w_sample;
    logic                r_periodic, r_done, w_busy, w_cfgHit;
    logic signed [PW-1:0] w_diff, w_base, w_k, w_prod, w_step;

    assign w_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_cfgHit = cfg_we && (cfg_ch == CHW'(n)) && !w_busy;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_td       <= '0;
        r_trExp    <= '0;
        r_th       <= CW'(1);
        r_tfExp    <= '0;
        r_tl       <= CW'(1);
        r_iv       <= '0;
        r_pv       <= '0;
        r_periodic <= 1'b0;
        r_count    <= '0;
      end else if (w_cfgHit) begin
        case (cfg_addr)
          3'd0: r_td    <= cfg_data[CW-1:0];
          3'd1: r_trExp <= cfg_data[EW-1:0];
          3'd2: r_th    <= cfg_data[CW-1:0];
          3'd3: r_tfExp <= cfg_data[EW-1:0];
          3'd4: r_tl    <= cfg_data[CW-1:0];
          3'd5: r_iv    <= cfg_data[W-1:0];
          3'd6: r_pv    <= cfg_data[W-1:0];
          default: begin
            r_periodic <= cfg_data[0];
            r_count    <= cfg_data[CW:1];
          end
        endcase
      end
    end

    // Ramp length minus one, i.e. the last k of a 2^e-cycle ramp.
    assign w_riseLast = ~(~CW'(0) << r_trExp);
    assign w_fallLast = ~(~CW'(0) << r_tfExp);
    assign w_perInc   = (r_per == '1) ? r_per : r_per + CW'(1);
    assign w_endState = ((r_count == '0) || (w_perInc < r_count)) ? S_RISE : S_DONE;

    always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt + CW'(1);
      w_nextPer   = r_per;
      if (w_busy && stop[n]) begin
        w_nextState = S_IDLE;
        w_nextCnt   = '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            w_nextCnt = '0;
            if (start[n] && !stop[n]) begin
              w_nextPer   = '0;
              w_nextState = (r_td == '0) ? S_RISE : S_DELAY;
            end
          end
          S_DELAY: begin
            if (r_cnt == r_td - CW'(1)) begin
              w_nextState = S_RISE;
              w_nextCnt   = '0;
            end
          end
          S_RISE: begin
            if (r_cnt == w_riseLast) begin
              w_nextCnt   = '0;
              w_nextState = (r_th != '0) ? S_HIGH : S_FALL;
            end
          end
          S_HIGH: begin
            if (r_cnt == r_th - CW'(1)) begin
              w_nextState = S_FALL;
              w_nextCnt   = '0;
            end
          end
          S_FALL: begin
            if (r_cnt == w_fallLast) begin
              w_nextCnt = '0;
              if (!r_periodic) begin
                w_nextState = S_DONE;
              end else if (r_tl != '0) begin
                w_nextState = S_LOW;
              end else begin
                w_nextState = w_endState;
                w_nextPer   = w_perInc;
              end
            end
          end
          S_LOW: begin
            if (r_cnt == r_tl - CW'(1)) begin
              w_nextState = w_endState;
              w_nextPer   = w_perInc;
              w_nextCnt   = '0;
            end
          end
          default: begin
            w_nextState = S_IDLE;
            w_nextCnt   = '0;
          end
        endcase
      end
    end

    // The sample is computed for the state being entered so the output register lines up with it.
    always_comb begin
      w_exp  = r_trExp;
      w_base = PW'(r_iv);
      w_diff = PW'(r_pv) - PW'(r_iv);
      if (w_nextState == S_FALL) begin
        w_exp  = r_tfExp;
        w_base = PW'(r_pv);
        w_diff = PW'(r_iv) - PW'(r_pv);
      end
      w_k    = PW'({1'b0, w_nextCnt});
      w_prod = w_diff * w_k;
      w_step = w_prod >>> w_exp;
      w_sample = r_iv;
      case (w_nextState)
        S_RISE, S_FALL: w_sample = W'(w_base + w_step);
        S_HIGH:         w_sample = r_pv;
        default:        w_sample = r_iv;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_per   <= '0;
        r_wave  <= '0;
        r_done  <= 1'b0;
      end else begin
        r_state <= w_nextState;
        r_cnt   <= w_nextCnt;
        r_per   <= w_nextPer;
        r_wave  <= w_sample;
        r_done  <= (w_nextState == S_DONE) && (r_state != S_DONE);
      end
    end

    assign busy[n]            = w_busy;
    assign done[n]            = r_done;
    assign wave_out[n*W +: W] = r_wave;
  end

endmodule

// File: tb/tb_pulse_source_gen.sv
// Scoreboard bench for pulse_source_gen: a waveform model expands each accepted start into
// the full expected per-cycle sample list, and a monitor pops and compares every cycle.
module tb_pulse_source_gen;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CW  = 16;
  localparam int EW  = 4;
  localparam int CHW = 2;
  localparam int DW  = 17;
  localparam int CAP = 200;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [2:0]       cfg_addr;
  logic [DW-1:0]    cfg_data;
  logic             cfg_err;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   stop;
  logic [NCH*W-1:0] wave_out;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done;

  pulse_source_gen #(.NCH(NCH), .W(W), .CW(CW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .start(start), .stop(stop),
    .wave_out(wave_out), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic         done;
    logic         busy;
    logic [W-1:0] wave;
  } exp_t;

  exp_t expQ[NCH][$];
  logic errQ[$];
  exp_t monExp;
  logic monErr;

  int mTd[NCH], mTrE[NCH], mTh[NCH], mTfE[NCH], mTl[NCH];
  int mIv[NCH], mPv[NCH], mCount[NCH], mPer[NCH];
  int busyEnd[NCH];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int ch, input logic [W+1:0] act,
                             input logic [W+1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s ch%0d cyc=%0d got=%h want=%h", name, ch, cyc, act, want);
    end
  endtask

  // Monitor: one expected entry per channel per cycle while a run is outstanding, idle otherwise.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (expQ[ch].size() > 0) begin
        monExp = expQ[ch].pop_front();
        checkOutput("sample", ch, {done[ch], busy[ch], wave_out[ch*W +: W]}, monExp);
      end else begin
        checkOutput("idle", ch, {{W{1'b0}}, done[ch], busy[ch]}, '0);
      end
    end
    monErr = (errQ.size() > 0) ? errQ.pop_front() : 1'b0;
    checkOutput("cfg_err", 0, {{(W+1){1'b0}}, cfg_err}, {{(W+1){1'b0}}, monErr});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] rampSample(int base, int target, int k, int e);
    longint num, den, q;
    num = longint'(target - base) * longint'(k);
    den = longint'(1) << e;
    q   = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    return W'(longint'(base) + q);
  endfunction

  task automatic pushExp(input int ch, input logic d, input logic b, input logic [W-1:0] wv);
    exp_t t;
    t.done = d;
    t.busy = b;
    t.wave = wv;
    expQ[ch].push_back(t);
  endtask

  function automatic bit isBusy(int ch);
    return cyc <= busyEnd[ch];
  endfunction

  task automatic modelStart(input int ch);
    int p;
    bit capped;
    p = 0;
    capped = 0;
    expQ[ch].delete();
    for (int i = 0; i < mTd[ch]; i++) pushExp(ch, 1'b0, 1'b1, W'(mIv[ch]));
    while (1) begin
      for (int k = 0; k < (1 << mTrE[ch]); k++)
        pushExp(ch, 1'b0, 1'b1, rampSample(mIv[ch], mPv[ch], k, mTrE[ch]));
      for (int i = 0; i < mTh[ch]; i++) pushExp(ch, 1'b0, 1'b1, W'(mPv[ch]));
      for (int k = 0; k < (1 << mTfE[ch]); k++)
        pushExp(ch, 1'b0, 1'b1, rampSample(mPv[ch], mIv[ch], k, mTfE[ch]));
      if (mPer[ch] == 0) break;
      for (int i = 0; i < mTl[ch]; i++) pushExp(ch, 1'b0, 1'b1, W'(mIv[ch]));
      p++;
      if (mCount[ch] != 0 && p >= mCount[ch]) break;
      if (expQ[ch].size() > CAP) begin
        capped = 1;
        break;
      end
    end
    busyEnd[ch] = cyc + expQ[ch].size();
    if (!capped) pushExp(ch, 1'b1, 1'b0, W'(mIv[ch]));
  endtask

  task automatic resetModel();
    for (int ch = 0; ch < NCH; ch++) begin
      mTd[ch] = 0; mTrE[ch] = 0; mTh[ch] = 1; mTfE[ch] = 0; mTl[ch] = 1;
      mIv[ch] = 0; mPv[ch] = 0; mCount[ch] = 0; mPer[ch] = 0;
      busyEnd[ch] = cyc;
      expQ[ch].delete();
      pushExp(ch, 1'b0, 1'b0, '0);
    end
    errQ.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    resetModel();
    tick();
    rst = 1'b0;
  endtask

  task automatic cfgWrite(input int ch, input int addr, input int data);
    logic [DW-1:0] d;
    d        = DW'(data);
    cfg_we   = 1'b1;
    cfg_ch   = CHW'(ch);
    cfg_addr = 3'(addr);
    cfg_data = d;
    if (isBusy(ch)) begin
      errQ.push_back(1'b1);
    end else begin
      errQ.push_back(1'b0);
      case (addr)
        0: mTd[ch]  = int'(d[CW-1:0]);
        1: mTrE[ch] = int'(d[EW-1:0]);
        2: mTh[ch]  = int'(d[CW-1:0]);
        3: mTfE[ch] = int'(d[EW-1:0]);
        4: mTl[ch]  = int'(d[CW-1:0]);
        5: mIv[ch]  = int'($signed(d[W-1:0]));
        6: mPv[ch]  = int'($signed(d[W-1:0]));
        default: begin
          mPer[ch]   = int'(d[0]);
          mCount[ch] = int'(d[CW:1]);
        end
      endcase
    end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic configure(input int ch, input int td, input int tr, input int th, input int tf,
                           input int tl, input int iv, input int pv, input int mode);
    cfgWrite(ch, 0, td); cfgWrite(ch, 1, tr); cfgWrite(ch, 2, th); cfgWrite(ch, 3, tf);
    cfgWrite(ch, 4, tl); cfgWrite(ch, 5, iv); cfgWrite(ch, 6, pv); cfgWrite(ch, 7, mode);
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] startMask, input logic [NCH-1:0] stopMask);
    start = startMask;
    stop  = stopMask;
    for (int ch = 0; ch < NCH; ch++) begin
      if (stopMask[ch]) begin
        if (isBusy(ch)) begin
          expQ[ch].delete();
          pushExp(ch, 1'b0, 1'b0, W'(mIv[ch]));
          busyEnd[ch] = cyc;
        end
      end else if (startMask[ch] && !isBusy(ch)) begin
        modelStart(ch);
      end
    end
    tick();
    start = '0;
    stop  = '0;
  endtask

  function automatic bit anyPending();
    for (int ch = 0; ch < NCH; ch++) if (expQ[ch].size() > 0) return 1;
    return 0;
  endfunction

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (anyPending() && n < maxCycles) begin
      tick();
      n++;
    end
    if (anyPending()) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout cyc=%0d got=pending want=empty", cyc);
    end
  endtask

  function automatic int randData(int addr);
    case (addr)
      5, 6:    return int'($urandom);
      7:       return (int'($urandom_range(1, 3)) << 1) | int'($urandom_range(0, 1));
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
    start = '0; stop = '0;
    doReset();
    repeat (2) tick();

    $display("[TB] single-shot ramp on ch0");
    configure(0, 2, 1, 3, 2, 1, 0, 100, 0);
    applyStimulus(4'b0001, 4'b0000);
    waitIdle(100);

    $display("[TB] periodic count=2 on ch1");
    configure(1, 0, 0, 2, 0, 2, -10, 10, (2 << 1) | 1);
    applyStimulus(4'b0010, 4'b0000);
    waitIdle(100);

    $display("[TB] odd ramp floor on ch2");
    configure(2, 0, 1, 1, 0, 1, 0, -3, 0);
    applyStimulus(4'b0100, 4'b0000);
    waitIdle(100);

    $display("[TB] abort of endless periodic run on ch3");
    configure(3, 1, 1, 1, 1, 1, 5, -20, 1);
    applyStimulus(4'b1000, 4'b0000);
    repeat (6) tick();
    applyStimulus(4'b1000, 4'b1000);
    repeat (3) tick();
    cfgWrite(3, 7, (1 << 1) | 1);
    applyStimulus(4'b1000, 4'b0000);
    waitIdle(100);

    $display("[TB] write to busy ch0 and idle ch2");
    applyStimulus(4'b0001, 4'b0000);
    repeat (3) tick();
    cfgWrite(0, 6, 77);
    cfgWrite(2, 6, 77);
    waitIdle(100);

    $display("[TB] reset during plateau on all channels");
    for (int ch = 0; ch < NCH; ch++) cfgWrite(ch, 2, 20);
    applyStimulus(4'b1111, 4'b0000);
    repeat (8) tick();
    doReset();
    tick();
    applyStimulus(4'b0001, 4'b0000);
    waitIdle(100);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 120; it++) begin
      int r, ch;
      r  = int'($urandom_range(0, 9));
      ch = int'($urandom_range(0, NCH - 1));
      if (r < 4 && !isBusy(ch)) begin
        for (int a = 0; a < 8; a++) cfgWrite(ch, a, randData(a));
        applyStimulus(NCH'(1) << ch, '0);
      end else if (r < 6) begin
        int a;
        a = int'($urandom_range(0, 7));
        cfgWrite(ch, a, randData(a));
      end else if (r < 7) begin
        applyStimulus('0, NCH'(1) << ch);
      end else if (r < 8) begin
        applyStimulus(NCH'($urandom_range(0, 15)), '0);
      end else begin
        repeat (int'($urandom_range(1, 4))) tick();
      end
    end
    waitIdle(2000);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
